// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and
// stream framing constants.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the
// program loader. The loader connects through the slave modport; whatever
// feeds the stream and watches the status uses the master modport.
interface program_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

endinterface

// File: rtl/program_loader_word_packer.sv
// word_packer: collects bytes (first byte least significant) into 32-bit
// words. word_end flags the strobe carrying the last byte of a word;
// word/word_valid present the completed word on the following cycle.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_data,
    input  logic        byte_stb,
    output logic        word_end,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_p0;
    logic [23:0] part_p0;
    logic [31:0] word_p1;
    logic        vld_p1;

    assign word_end   = byte_stb && (idx_p0 == LAST_IDX);
    assign word       = word_p1;
    assign word_valid = vld_p1;

    // Byte position within the current word and the one-cycle word strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_p0 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= word_end;
            if (byte_stb)
                idx_p0 <= word_end ? 2'd0 : idx_p0 + 2'd1;
        end
    end

    // Partial word shifts in from the top so the first byte ends up lowest.
    always_ff @(posedge clk) begin
        if (byte_stb && !word_end)
            part_p0 <= {byte_data, part_p0[23:8]};
    end

    // Completed word; cleared by reset so the write bus idles at zero.
    always_ff @(posedge clk) begin
        if (reset)
            word_p1 <= '0;
        else if (word_end)
            word_p1 <= {byte_data, part_p0};
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a byte stream (16-bit LE word count, then the
// words LE), writes each word to instruction memory and holds the CPU in
// reset until the whole program is in place.
// Optional feature macro LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// over all data bytes is checked before the load is declared done.
module program_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    program_loader_if.slave bus
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    loader_state_t state, state_nx;

    logic        xfer;
    logic        pk_stb;
    logic        word_end;
    logic        word_vld;
    logic        last_word;
    logic [31:0] word;
    logic [7:0]  n_lo;
    logic [15:0] hdr_n;
    logic [15:0] n_words;
    logic [15:0] wcnt;
    logic [31:0] addr;

    assign hdr_n     = {bus.in_data, n_lo};
    assign xfer      = bus.in_valid && bus.in_ready;
    assign pk_stb    = xfer && (state == ST_DATA);
    // The previous word is always written before the next one completes,
    // so wcnt equals the index of the word now being finished.
    assign last_word = word_end && (wcnt == n_words - 16'd1);

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (bus.in_data),
        .byte_stb   (pk_stb),
        .word_end   (word_end),
        .word       (word),
        .word_valid (word_vld)
    );

    // Header bytes; only meaningful once the matching header state has passed.
    always_ff @(posedge clk) begin
        if (xfer && state == ST_HDR0)
            n_lo <= bus.in_data;
        if (xfer && state == ST_HDR1)
            n_words <= hdr_n;
    end

    // Word counter and write address advance once per memory write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
            addr <= BASE_ADDR;
        end else if (word_vld) begin
            wcnt <= wcnt + 16'd1;
            addr <= addr + 32'd4;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of every data byte accepted.
    always_ff @(posedge clk) begin
        if (reset)
            csum <= '0;
        else if (pk_stb)
            csum <= csum ^ bus.in_data;
    end
`else
    logic fin_p1;

    // Marks the cycle of the final write (or the empty-program header) so
    // DONE is entered on the cycle after it.
    always_ff @(posedge clk) begin
        if (reset)
            fin_p1 <= 1'b0;
        else
            fin_p1 <= (xfer && state == ST_HDR1 && hdr_n == 16'd0) || last_word;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_HDR0;
        else
            state <= state_nx;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nx       = state;
        bus.in_ready   = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = addr;
        bus.imem_wdata = word;
        bus.cpu_reset  = 1'b1;
        bus.done       = 1'b0;
        bus.error      = 1'b0;

        case (state)
            ST_HDR0: begin
                if (xfer)
                    state_nx = ST_HDR1;
            end
            ST_HDR1: begin
                if (xfer) begin
                    if ({16'd0, hdr_n} > MAX_W)
                        state_nx = ST_ERROR;
`ifdef LOADER_CHECKSUM_EN
                    else if (hdr_n == 16'd0)
                        state_nx = ST_CSUM;
`endif
                    else
                        state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (last_word)
                    state_nx = ST_CSUM;
`else
                if (fin_p1)
                    state_nx = ST_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer)
                    state_nx = (bus.in_data == csum) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE:  ;
            ST_ERROR: ;
            default:  state_nx = ST_ERROR;
        endcase

        if (!reset) begin
            bus.in_ready  = (state == ST_HDR0) || (state == ST_HDR1) ||
                            (state == ST_DATA) || (state == ST_CSUM);
            bus.imem_we   = word_vld && (state != ST_ERROR);
            bus.cpu_reset = (state != ST_DONE);
            bus.done      = (state == ST_DONE);
            bus.error     = (state == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed streams plus randomized
// programs and stalls, compared against a stream-level reference model.
module tb_program_loader;

    localparam int          MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader #(
        .MAX_WORDS (MAXW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int end_cyc = -1;
    int width_bad = 0;
    bit prev_we = 1'b0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [7:0]  stim[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    int exp_out;    // 1 = done, 2 = error
    int exp_cons;   // bytes the loader should accept
    int exp_lat;    // cycles from last accepted byte to done/error visible

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and log what the DUT shows there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.imem_we === 1'b1) begin
            got_a.push_back(bus.imem_addr);
            got_d.push_back(bus.imem_wdata);
            if (prev_we) width_bad++;
        end
        prev_we = (bus.imem_we === 1'b1);
        if (end_cyc < 0 && (bus.done === 1'b1 || bus.error === 1'b1))
            end_cyc = cyc;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("rst.in_ready", bus.in_ready, 0);
        check("rst.imem_we", bus.imem_we, 0);
        check("rst.cpu_reset", bus.cpu_reset, 1);
        check("rst.done", bus.done, 0);
        check("rst.error", bus.error, 0);
        check("rst.imem_addr", bus.imem_addr, BASE);
        check("rst.imem_wdata", bus.imem_wdata, 0);
        reset = 1'b0;
        tick();
        check("rst.hdr0_ready", bus.in_ready, 1);
        got_a.delete();
        got_d.delete();
        end_cyc = -1;
        width_bad = 0;
        prev_we = 1'b0;
    endtask

    // Stream-level reference: what the loader must write and how it ends.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_a.delete();
        exp_d.delete();
        n = int'({stim[1], stim[0]});
        if (n > MAXW) begin
            exp_out = 2;
            exp_cons = 2;
            exp_lat = 1;
        end else begin
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                int b = 2 + 4 * k;
                exp_a.push_back(BASE + 32'(4 * k));
                exp_d.push_back({stim[b + 3], stim[b + 2], stim[b + 1], stim[b]});
                x = x ^ stim[b] ^ stim[b + 1] ^ stim[b + 2] ^ stim[b + 3];
            end
            exp_out = 1;
            exp_cons = 2 + 4 * n;
            exp_lat = 2;
`ifdef LOADER_CHECKSUM_EN
            exp_cons = exp_cons + 1;
            exp_lat = 1;
            if (stim[2 + 4 * n] != x) exp_out = 2;
`endif
        end
    endtask

    task automatic make_stream(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        stim.delete();
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        x = 8'h00;
        if (n > MAXW) begin
            for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                stim.push_back(b);
            end
`ifdef LOADER_CHECKSUM_EN
            stim.push_back(corrupt ? ~x : x);
`else
            if (corrupt) stim.push_back(x);
`endif
        end
    endtask

    task automatic run_case(input string tag, input int smin, input int smax);
        int acc;
        int last;
        model();
        acc = 0;
        last = 0;
        foreach (stim[i]) begin
            repeat ($urandom_range(smax, smin)) begin
                tick();
                bus.in_valid = 1'b0;
            end
            tick();
            bus.in_valid = 1'b1;
            bus.in_data = stim[i];
            if (bus.in_ready === 1'b1) begin
                acc++;
                last = cyc;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 50 && end_cyc < 0; k++) tick();
        repeat (3) begin
            tick();
            bus.in_valid = 1'b1;
            bus.in_data = 8'($urandom);
            if (bus.in_ready === 1'b1) acc++;
        end
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check({tag, ".end_seen"}, end_cyc >= 0, 1);
        check({tag, ".latency"}, end_cyc - last, exp_lat);
        check({tag, ".accepted"}, acc, exp_cons);
        check({tag, ".nwrites"}, got_a.size(), exp_a.size());
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
            check({tag, ".addr"}, got_a[k], exp_a[k]);
            check({tag, ".data"}, got_d[k], exp_d[k]);
        end
        check({tag, ".done"}, bus.done, exp_out == 1);
        check({tag, ".error"}, bus.error, exp_out == 2);
        check({tag, ".cpu_reset"}, bus.cpu_reset, exp_out != 1);
        check({tag, ".in_ready"}, bus.in_ready, 0);
        check({tag, ".we_idle"}, bus.imem_we, 0);
        check({tag, ".we_width"}, width_bad, 0);
    endtask

    task automatic load_ref_stream();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h90);
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;

        // Reference two-word program, back to back.
        do_reset();
        load_ref_stream();
        run_case("ref", 0, 0);
        if (got_d.size() >= 2) begin
            check("ref.word0", got_d[0], 32'h00A00513);
            check("ref.word1", got_d[1], 32'h00B00593);
            check("ref.addr1", got_a[1], 32'h4);
        end

        // Same program with three idle cycles around every byte.
        do_reset();
        load_ref_stream();
        run_case("stall3", 3, 3);

        // Empty program.
        do_reset();
        make_stream(0, 1'b0);
        run_case("empty", 0, 0);

        // Oversized header followed by bytes that must be ignored.
        do_reset();
        make_stream(257, 1'b0);
        run_case("too_big", 0, 1);

        // Largest accepted program.
        do_reset();
        make_stream(MAXW, 1'b0);
        run_case("max", 0, 0);

        // Reset in the middle of a load, then a clean load.
        do_reset();
        load_ref_stream();
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.in_valid = 1'b1;
            bus.in_data = stim[i];
        end
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("midrst.no_write", got_a.size(), 0);
        do_reset();
        run_case("midrst", 0, 0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        load_ref_stream();
        stim[stim.size() - 1] = 8'hFF;
        run_case("csum_bad", 0, 0);
`endif

        // Randomized programs and stall patterns.
        for (int it = 0; it < 10; it++) begin
            do_reset();
            make_stream($urandom_range(5, 0), 1'($urandom_range(1, 0)) & 1'b0 |
`ifdef LOADER_CHECKSUM_EN
                        1'($urandom_range(1, 0))
`else
                        1'b0
`endif
                        );
            run_case("rnd", 0, $urandom_range(3, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
